uart_rx_axis_bridge: RTL and testbench
======================================

// Module: uart_rx_axis_bridge
// PURPOSE
//   Downstream of the UART receiver. Buffers received bytes in a FIFO and presents
//   them as an AXI4-Stream master. Frames bytes into packets: m_axis_tlast marks the
//   last byte before a line-idle gap of IDLE_TIMEOUT clk cycles.
//   Keeps saturating overflow and parity-error statistics.
// PARAMETERS
//   DATA_BITS     8     byte width; must match the UART receiver
//   FIFO_DEPTH    16    entries; power of 2, >= 2
//   IDLE_TIMEOUT  1000  idle clk cycles that close a frame; 0 = no framing (tlast always 0)
//   CNT_WIDTH     16    width of the statistics counters
// PORTS
//   clk             in   1                     clock
//   rst             in   1                     reset, asynchronous, active-high
//   rx_data         in   DATA_BITS             byte from UART receiver; valid with rx_valid or parity_error
//   rx_valid        in   1                     1-cycle pulse: good byte
//   parity_error    in   1                     1-cycle pulse: byte with bad parity (never together with rx_valid)
//   m_axis_tdata    out  DATA_BITS             head-of-FIFO byte
//   m_axis_tvalid   out  1                     head byte presentable
//   m_axis_tready   in   1                     sink accepts
//   m_axis_tlast    out  1                     head byte closes a frame
//   m_axis_tuser    out  1                     head byte had a parity error (PARITY_TUSER_EN only; else 0)
//   fifo_level      out  $clog2(FIFO_DEPTH)+1  number of stored entries
//   overflow_cnt    out  CNT_WIDTH             bytes dropped because the FIFO was full; saturates at all-ones
//   parity_err_cnt  out  CNT_WIDTH             parity_error pulses seen; saturates at all-ones
//   clear_cnt       in   1                     synchronous clear of both counters
// BEHAVIOUR
//   Reset:
//   - Pointers, fifo_level, counters, idle_cnt and frame_open are all 0.
//   - All outputs are 0.
//   Write:
//   - Event = rx_valid, or parity_error when PARITY_TUSER_EN is defined.
//   - Not full: store {tuser, tlast=0, rx_data} at wr_ptr and increment wr_ptr.
//   - Full: drop the byte and increment overflow_cnt.
//   Idle timer:
//   - Any rx_valid or parity_error (stored or dropped) clears idle_cnt to 0.
//   - A successful write sets frame_open.
//   - Otherwise idle_cnt increments, saturating at IDLE_TIMEOUT.
//   - If idle_cnt == IDLE_TIMEOUT-1, frame_open = 1 and there is no event: set the
//     tlast bit of entry wr_ptr-1 and clear frame_open.
//   - Result: tlast is marked exactly IDLE_TIMEOUT edges after the last write.
//   Presentation:
//   - m_axis_tvalid = !empty && !(fifo_level == 1 && frame_open).
//   - The last-written byte is held until either a later byte arrives (it goes out
//     with tlast = 0) or the timeout marks it (it goes out with tlast = 1).
//   - Consequence: tdata/tlast/tuser never change while tvalid && !tready.
//   - IDLE_TIMEOUT = 0: frame_open is never set, tlast is always 0, no hold.
//   Read:
//   - tvalid && tready pops the head. Data is FWFT from the memory; combinational
//     read of the head entry is allowed.
//   - Latency: byte written at edge E is visible after E when it is not held.
//   Simultaneous events:
//   - Write and read in the same cycle: both happen and fifo_level is unchanged.
//   - Write while full with a read in the same cycle: the write is accepted, not dropped.
//   - Timeout and write in the same cycle: the write wins and no tlast is set.
//   Counters:
//   - Saturate at all-ones.
//   - clear_cnt has priority over an increment in the same cycle (result is 0).
//   Reset mid-operation:
//   - FIFO is emptied, any open frame is discarded, tvalid drops asynchronously.
// CONFIGURATION
//   PARITY_TUSER_EN defined:
//   - Bytes flagged by parity_error are stored with tuser = 1 and parity_err_cnt increments.
//   PARITY_TUSER_EN undefined:
//   - Bytes flagged by parity_error are dropped; parity_err_cnt still increments;
//     the idle timer still restarts.
//   - m_axis_tuser is tied to 0.
// TESTING
//   1 Reset: assert rst -> all outputs 0, fifo_level = 0; release -> still idle.
//   2 IDLE_TIMEOUT=8, tready=1, bytes 0x11,0x22,0x33 three cycles apart
//     -> 0x11 and 0x22 out with tlast=0; 0x33 out with tlast=1, tvalid rising
//     8 edges after its write.
//   3 FIFO_DEPTH=4, tready=0, five bytes 0x01..0x05 -> fifo_level=4, overflow_cnt=1;
//     drain -> 0x01..0x04 in order, tdata stable while stalled.
//   4 parity_error pulse with 0xA5 -> without macro: nothing stored, parity_err_cnt=1;
//     with macro: 0xA5 out with tuser=1.
//   5 fifo_level=2, write and pop in the same cycle -> fifo_level stays 2;
//     clear_cnt during an overflow -> overflow_cnt=0.
//   6 rst asserted with 3 entries and frame_open set -> fifo_level=0, tvalid=0,
//     counters 0; the next byte starts a new frame.

Source files
------------

// File: rtl/uart_rx_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_axis_bridge
// Purpose  : FIFO-buffered AXI4-Stream master for UART RX bytes; closes frames
//            with tlast after an idle gap and keeps saturating overflow and
//            parity-error counters. Optional macro: PARITY_TUSER_EN (store
//            parity-flagged bytes with tuser = 1 instead of dropping them).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_axis_bridge #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          rx_data,
    input  logic                          rx_valid,
    input  logic                          parity_error,
    output logic [DATA_BITS-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_WIDTH-1:0]          overflow_cnt,
    output logic [CNT_WIDTH-1:0]          parity_err_cnt,
    input  logic                          clear_cnt
);

    localparam int C_ADDR_W    = $clog2(FIFO_DEPTH);
    localparam int C_LVL_W     = C_ADDR_W + 1;
    localparam int C_ENTRY_W   = DATA_BITS + 2;
    localparam int C_TLAST_BIT = DATA_BITS;
    localparam int C_TUSER_BIT = DATA_BITS + 1;
    localparam int C_IDLE_W    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [C_ADDR_W-1:0]  C_ADDR_ONE = C_ADDR_W'(1);
    localparam logic [C_LVL_W-1:0]   C_LVL_ONE  = C_LVL_W'(1);
    localparam logic [C_LVL_W-1:0]   C_LVL_FULL = C_LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX  = '1;

    // Entry layout: {tuser, tlast, data}
    logic [C_ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [C_ENTRY_W-1:0] mem_d [FIFO_DEPTH];

    logic [C_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C_LVL_W-1:0]   level_q, level_d;
    logic [C_IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic                 frame_open_q, frame_open_d;
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;

    logic                 w_wr_evt;
    logic                 w_wr_user;
    logic                 w_any_evt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_tvalid;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_drop;
    logic                 w_mark;
    logic [C_ADDR_W-1:0]  w_last_ptr;

`ifdef PARITY_TUSER_EN
    assign w_wr_evt  = rx_valid | parity_error;
    assign w_wr_user = parity_error;
`else
    assign w_wr_evt  = rx_valid;
    assign w_wr_user = 1'b0;
`endif

    assign w_any_evt  = rx_valid | parity_error;
    assign w_full     = (level_q == C_LVL_FULL);
    assign w_empty    = (level_q == '0);
    // The newest byte of an open frame is withheld until its tlast is known.
    assign w_tvalid   = !w_empty && !((level_q == C_LVL_ONE) && frame_open_q);
    assign w_pop      = w_tvalid && m_axis_tready;
    assign w_wr_en    = w_wr_evt && (!w_full || w_pop);
    assign w_drop     = w_wr_evt && !w_wr_en;
    assign w_last_ptr = wr_ptr_q - C_ADDR_ONE;

    generate
        if (IDLE_TIMEOUT > 0) begin : g_framing
            localparam logic [C_IDLE_W-1:0] C_IDLE_MAX  = C_IDLE_W'(IDLE_TIMEOUT);
            localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(IDLE_TIMEOUT - 1);
            localparam logic [C_IDLE_W-1:0] C_IDLE_ONE  = C_IDLE_W'(1);

            always_comb begin
                idle_cnt_d   = idle_cnt_q;
                frame_open_d = frame_open_q;
                w_mark       = 1'b0;
                if (w_any_evt) begin
                    idle_cnt_d = '0;
                    if (w_wr_en) begin
                        frame_open_d = 1'b1;
                    end
                end else begin
                    if (idle_cnt_q != C_IDLE_MAX) begin
                        idle_cnt_d = idle_cnt_q + C_IDLE_ONE;
                    end
                    if ((idle_cnt_q == C_IDLE_LAST) && frame_open_q) begin
                        w_mark       = 1'b1;
                        frame_open_d = 1'b0;
                    end
                end
            end
        end else begin : g_no_framing
            assign idle_cnt_d   = '0;
            assign frame_open_d = 1'b0;
            assign w_mark       = 1'b0;
        end
    endgenerate

    // A write and a timeout mark are mutually exclusive: marking needs a quiet cycle.
    always_comb begin
        mem_d = mem_q;
        if (w_wr_en) begin
            mem_d[wr_ptr_q] = {w_wr_user, 1'b0, rx_data};
        end else if (w_mark) begin
            mem_d[w_last_ptr][C_TLAST_BIT] = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + C_ADDR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + C_ADDR_ONE;
        end
        if (w_wr_en && !w_pop) begin
            level_d = level_q + C_LVL_ONE;
        end else if (!w_wr_en && w_pop) begin
            level_d = level_q - C_LVL_ONE;
        end
    end

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        par_cnt_d = par_cnt_q;
        if (clear_cnt) begin
            ovf_cnt_d = '0;
            par_cnt_d = '0;
        end else begin
            if (w_drop && (ovf_cnt_q != C_CNT_MAX)) begin
                ovf_cnt_d = ovf_cnt_q + C_CNT_ONE;
            end
            if (parity_error && (par_cnt_q != C_CNT_MAX)) begin
                par_cnt_d = par_cnt_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            idle_cnt_q   <= '0;
            frame_open_q <= 1'b0;
            ovf_cnt_q    <= '0;
            par_cnt_q    <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            idle_cnt_q   <= idle_cnt_d;
            frame_open_q <= frame_open_d;
            ovf_cnt_q    <= ovf_cnt_d;
            par_cnt_q    <= par_cnt_d;
        end
    end

    // Head fields are gated so stale or uninitialised memory never reaches the port.
    assign m_axis_tvalid  = w_tvalid;
    assign m_axis_tdata   = w_tvalid ? mem_q[rd_ptr_q][DATA_BITS-1:0] : '0;
    assign m_axis_tlast   = w_tvalid & mem_q[rd_ptr_q][C_TLAST_BIT];
`ifdef PARITY_TUSER_EN
    assign m_axis_tuser   = w_tvalid & mem_q[rd_ptr_q][C_TUSER_BIT];
`else
    assign m_axis_tuser   = 1'b0;
`endif
    assign fifo_level     = level_q;
    assign overflow_cnt   = ovf_cnt_q;
    assign parity_err_cnt = par_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_axis_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_axis_bridge
// Purpose  : Directed and randomized checks of uart_rx_axis_bridge against a
//            timestamp-based model of framing, ordering and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_axis_bridge;

    localparam int DATA_BITS    = 8;
    localparam int FIFO_DEPTH   = 4;
    localparam int IDLE_TIMEOUT = 8;
    localparam int CNT_WIDTH    = 3;
    localparam int NEV          = 60;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic [DATA_BITS-1:0] m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;
    logic [2:0]           fifo_level;
    logic [CNT_WIDTH-1:0] overflow_cnt;
    logic [CNT_WIDTH-1:0] parity_err_cnt;
    logic                 clear_cnt;

    always #5 clk = ~clk;

    uart_rx_axis_bridge #(
        .DATA_BITS    (DATA_BITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .parity_error   (parity_error),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .fifo_level     (fifo_level),
        .overflow_cnt   (overflow_cnt),
        .parity_err_cnt (parity_err_cnt),
        .clear_cnt      (clear_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    beat_t      got_q[$];
    beat_t      held;
    beat_t      exp_b;
    logic       stalled = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         edge_n = 0;
    int         popped_n = 0;
    int         stored_n = 0;
    int         npar = 0;
    int         early = 0;
    int         w = 0;
    int         gap = 0;
    int         k = 0;
    int         prev = 0;
    int         exp_par = 0;
    logic       lst;
    logic       ptype;
    logic [7:0] data;

    int         ev_edge [NEV];
    logic       ev_st   [NEV];
    logic [7:0] ev_d    [NEV];
    logic       ev_u    [NEV];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                    32'({1'b1, held}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back('{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser});
                popped_n++;
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
        end
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic par);
        rx_data      = b;
        rx_valid     = !par;
        parity_error = par;
        tick();
        rx_valid     = 1'b0;
        parity_error = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; parity_error = 1'b0;
        m_axis_tready = 1'b0; clear_cnt = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
        chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
        chk("rst_tuser",  32'(m_axis_tuser),  32'd0);
        chk("rst_level",  32'(fifo_level),    32'd0);
        chk("rst_ovf",    32'(overflow_cnt),  32'd0);
        chk("rst_par",    32'(parity_err_cnt), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("idle_level",  32'(fifo_level),    32'd0);

        // Framing: three bytes three cycles apart, last one closed by the idle timeout
        got_q.delete();
        m_axis_tready = 1'b1;
        send(8'h11, 1'b0); repeat (2) tick();
        send(8'h22, 1'b0); repeat (2) tick();
        send(8'h33, 1'b0);
        early = 0;
        for (int i = 1; i < IDLE_TIMEOUT; i++) begin
            tick();
            if (m_axis_tvalid) early++;
        end
        chk("frame_held", 32'(early), 32'd0);
        tick();
        chk("frame_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("frame_tdata",  32'(m_axis_tdata),  32'h33);
        chk("frame_tlast",  32'(m_axis_tlast),  32'd1);
        tick();
        chk("frame_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("frame_b0", 32'(got_q[0]), 32'({8'h11, 1'b0, 1'b0}));
            chk("frame_b1", 32'(got_q[1]), 32'({8'h22, 1'b0, 1'b0}));
            chk("frame_b2", 32'(got_q[2]), 32'({8'h33, 1'b1, 1'b0}));
        end

        // Overflow with a stalled sink, then drain
        got_q.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
        chk("ovf_level", 32'(fifo_level),   32'd4);
        chk("ovf_cnt",   32'(overflow_cnt), 32'd1);
        chk("ovf_head",  32'(m_axis_tdata), 32'h01);
        repeat (3) tick();
        chk("ovf_head_stall", 32'(m_axis_tdata), 32'h01);
        m_axis_tready = 1'b1;
        repeat (14) tick();
        chk("drain_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size())
                chk("drain_beat", 32'(got_q[i]), 32'({8'(i + 1), (i == 3), 1'b0}));
        end

        // Parity-flagged byte
        got_q.delete();
        send(8'hA5, 1'b1);
        chk("par_cnt", 32'(parity_err_cnt), 32'd1);
`ifdef PARITY_TUSER_EN
        chk("par_level", 32'(fifo_level), 32'd1);
`else
        chk("par_level", 32'(fifo_level), 32'd0);
`endif
        repeat (12) tick();
`ifdef PARITY_TUSER_EN
        chk("par_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("par_beat", 32'(got_q[0]), 32'({8'hA5, 1'b1, 1'b1}));
`else
        chk("par_count", 32'(got_q.size()), 32'd0);
`endif

        // Simultaneous write/read, clear during overflow, write while full with read
        got_q.delete();
        m_axis_tready = 1'b0;
        send(8'h40, 1'b0);
        send(8'h41, 1'b0);
        chk("wr_rd_pre", 32'(fifo_level), 32'd2);
        m_axis_tready = 1'b1;
        send(8'h42, 1'b0);
        m_axis_tready = 1'b0;
        chk("wr_rd_level", 32'(fifo_level), 32'd2);
        send(8'h43, 1'b0);
        send(8'h44, 1'b0);
        chk("full_level", 32'(fifo_level),   32'd4);
        chk("ovf_before", 32'(overflow_cnt), 32'd1);
        clear_cnt = 1'b1;
        send(8'h45, 1'b0);
        clear_cnt = 1'b0;
        chk("clr_ovf",     32'(overflow_cnt), 32'd0);
        chk("clr_par",     32'(parity_err_cnt), 32'd0);
        chk("clr_level",   32'(fifo_level),   32'd4);
        m_axis_tready = 1'b1;
        send(8'h46, 1'b0);
        m_axis_tready = 1'b0;
        chk("fullrd_level", 32'(fifo_level),   32'd4);
        chk("fullrd_ovf",   32'(overflow_cnt), 32'd0);
        m_axis_tready = 1'b1;
        repeat (14) tick();
        chk("sim_count", 32'(got_q.size()), 32'd6);
        if (got_q.size() == 6) begin
            chk("sim_b0", 32'(got_q[0]), 32'({8'h40, 1'b0, 1'b0}));
            chk("sim_b1", 32'(got_q[1]), 32'({8'h41, 1'b0, 1'b0}));
            chk("sim_b4", 32'(got_q[4]), 32'({8'h44, 1'b0, 1'b0}));
            chk("sim_b5", 32'(got_q[5]), 32'({8'h46, 1'b1, 1'b0}));
        end

        // Parity counter saturation
        for (int i = 0; i < 9; i++) begin
            send(8'(i), 1'b1);
            tick();
        end
        chk("par_sat", 32'(parity_err_cnt), 32'd7);
        repeat (12) tick();

        // Asynchronous reset with an open frame holding three entries
        got_q.delete();
        m_axis_tready = 1'b0;
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        chk("mid_level", 32'(fifo_level), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("arst_tvalid", 32'(m_axis_tvalid),  32'd0);
        chk("arst_level",  32'(fifo_level),     32'd0);
        chk("arst_par",    32'(parity_err_cnt), 32'd0);
        chk("arst_ovf",    32'(overflow_cnt),   32'd0);
        repeat (2) tick();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        send(8'h77, 1'b0);
        repeat (12) tick();
        chk("arst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("arst_beat", 32'(got_q[0]), 32'({8'h77, 1'b1, 1'b0}));

        // Randomized traffic against the timestamp model
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        got_q.delete();
        popped_n = 0; stored_n = 0; npar = 0;
        for (int i = 0; i < NEV; i++) begin
            gap = $urandom_range(0, 11);
            for (int g = 0; g < gap; g++) begin
                m_axis_tready = ($urandom_range(0, 3) != 0);
                tick();
            end
            w = 0;
            while ((stored_n - popped_n >= FIFO_DEPTH - 1) && (w < 50)) begin
                m_axis_tready = 1'b1;
                tick();
                w++;
            end
            if (w >= 50) chk("flow_budget", 32'(stored_n - popped_n < FIFO_DEPTH - 1), 32'd1);
            ptype = ($urandom_range(0, 4) == 0);
            data  = 8'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
            send(data, ptype);
            ev_edge[i] = edge_n;
            ev_d[i]    = data;
            ev_u[i]    = ptype;
`ifdef PARITY_TUSER_EN
            ev_st[i]   = 1'b1;
`else
            ev_st[i]   = !ptype;
`endif
            if (ev_st[i]) stored_n++;
            if (ptype) npar++;
        end
        m_axis_tready = 1'b1;
        repeat (3 * IDLE_TIMEOUT) tick();

        chk("rand_count", 32'(got_q.size()), 32'(stored_n));
        k = 0;
        for (int i = 0; i < NEV; i++) begin
            if (ev_st[i]) begin
                // tlast unless the next stored byte arrives before any quiet gap > timeout
                lst  = 1'b1;
                prev = ev_edge[i];
                for (int m = i + 1; m < NEV; m++) begin
                    if (ev_edge[m] - prev > IDLE_TIMEOUT) break;
                    prev = ev_edge[m];
                    if (ev_st[m]) begin
                        lst = 1'b0;
                        break;
                    end
                end
                exp_b = '{d: ev_d[i], l: lst, u: ev_u[i]};
                if (k < got_q.size()) chk("rand_beat", 32'(got_q[k]), 32'(exp_b));
                k++;
            end
        end
        exp_par = (npar > 7) ? 7 : npar;
        chk("rand_ovf", 32'(overflow_cnt),   32'd0);
        chk("rand_par", 32'(parity_err_cnt), 32'(exp_par));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
